// File: rtl/priority_arbiter_8.sv
// Eight-requester arbiter with fixed (index 7 highest) or round-robin selection,
// a registered one-hot grant with its index, and release/drop/timeout revocation.
module priority_arbiter_8 #(
    parameter int unsigned MAX_HOLD_CYCLES = 16
) (
    input  logic       Clock_In,
    input  logic       Reset_In,
    input  logic [7:0] Request_In,
    input  logic       Release_In,
    input  logic       Mode_In,
    output logic [7:0] Grant_Out,
    output logic [2:0] Grant_Index_Out,
    output logic       Grant_Valid_Out,
    output logic       Timeout_Out
);

    localparam int unsigned N  = 8;
    localparam int unsigned IW = 3;
    localparam int unsigned CW = 16;
    localparam logic            TIMEOUT_EN = (MAX_HOLD_CYCLES != 0);
    localparam logic [CW-1:0]   HOLD_LAST  = CW'(MAX_HOLD_CYCLES) - CW'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY     = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    state_t          state_q;
    logic [N-1:0]    grant_q;
    logic [IW-1:0]   index_q;
    logic            valid_q;
    logic            timeout_q;
    logic [IW-1:0]   last_q;
    logic [CW-1:0]   hold_q;

    logic [IW-1:0]   fixed_idx_c;
    logic [IW-1:0]   rr_idx_c;
    logic [IW-1:0]   probe_c;
    logic [IW-1:0]   win_idx_c;
    logic            owner_end_c;
    logic            timeout_c;

    // Winner selection; later loop iterations overwrite earlier ones, so the
    // last match is the highest index (fixed) or the nearest after last_q (RR).
    always_comb begin
        fixed_idx_c = '0;
        rr_idx_c    = '0;
        probe_c     = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (Request_In[i]) begin
                fixed_idx_c = IW'(i);
            end
        end
        for (int k = int'(N); k >= 1; k--) begin
            probe_c = last_q + IW'(k);
            if (Request_In[probe_c]) begin
                rr_idx_c = probe_c;
            end
        end
        win_idx_c = Mode_In ? rr_idx_c : fixed_idx_c;
    end

    assign owner_end_c = Release_In || !Request_In[index_q];
    assign timeout_c   = TIMEOUT_EN && (hold_q == HOLD_LAST);

    always_ff @(posedge Clock_In or posedge Reset_In) begin
        if (Reset_In) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            index_q   <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            last_q    <= IW'(7);
            hold_q    <= '0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|Request_In) begin
                        state_q <= BUSY;
                        grant_q <= N'(1) << win_idx_c;
                        index_q <= win_idx_c;
                        valid_q <= 1'b1;
                        last_q  <= win_idx_c;
                        hold_q  <= '0;
                    end
                end
                BUSY: begin
                    hold_q <= hold_q + CW'(1);
                    if (owner_end_c || timeout_c) begin
                        state_q   <= COOLDOWN;
                        grant_q   <= '0;
                        index_q   <= '0;
                        valid_q   <= 1'b0;
                        // A coincident release or drop suppresses the timeout pulse.
                        timeout_q <= timeout_c && !owner_end_c;
                    end
                end
                COOLDOWN: state_q <= IDLE;
                default:  state_q <= IDLE;
            endcase
        end
    end

    assign Grant_Out       = grant_q;
    assign Grant_Index_Out = index_q;
    assign Grant_Valid_Out = valid_q;
    assign Timeout_Out     = timeout_q;

endmodule

// File: tb/tb_priority_arbiter_8.sv
// Bench for priority_arbiter_8: directed scenarios plus random traffic, all
// checked against a cycle-level behavioural model of the arbitration rules.
module tb_priority_arbiter_8;

    localparam int unsigned MAXH = 4;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       rel;
    logic       mode;
    logic [7:0] grant;
    logic [2:0] gidx;
    logic       gvalid;
    logic       tmo;

    int checks   = 0;
    int failures = 0;

    // Model: current owner (-1 none), BUSY edges since grant, last winner, cooldown flag.
    int m_owner;
    int m_edges;
    int m_last;
    bit m_cool;
    bit m_tmo;

    priority_arbiter_8 #(.MAX_HOLD_CYCLES(MAXH)) dut (
        .Clock_In        (clk),
        .Reset_In        (rst),
        .Request_In      (req),
        .Release_In      (rel),
        .Mode_In         (mode),
        .Grant_Out       (grant),
        .Grant_Index_Out (gidx),
        .Grant_Valid_Out (gvalid),
        .Timeout_Out     (tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_owner = -1;
        m_edges = 0;
        m_last  = 7;
        m_cool  = 1'b0;
        m_tmo   = 1'b0;
    endfunction

    function automatic void model_edge();
        bit ended_by_owner;
        bit ended_by_time;
        m_tmo = 1'b0;
        if (m_cool) begin
            m_cool = 1'b0;
        end else if (m_owner < 0) begin
            if (req != 8'h00) begin
                if (!mode) begin
                    for (int i = 7; i >= 0; i--)
                        if (m_owner < 0 && req[i]) m_owner = i;
                end else begin
                    for (int k = 1; k <= 8; k++)
                        if (m_owner < 0 && req[(m_last + k) % 8]) m_owner = (m_last + k) % 8;
                end
                m_last  = m_owner;
                m_edges = 0;
            end
        end else begin
            m_edges++;
            ended_by_owner = rel || !req[m_owner];
            ended_by_time  = (MAXH != 0) && (m_edges == int'(MAXH));
            if (ended_by_owner || ended_by_time) begin
                m_tmo   = ended_by_time && !ended_by_owner;
                m_owner = -1;
                m_cool  = 1'b1;
            end
        end
    endfunction

    task automatic compare_model();
        logic [7:0] eg;
        eg = (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
        check("grant", 32'(grant), 32'(eg));
        check("index", 32'(gidx), (m_owner < 0) ? 32'd0 : 32'(m_owner));
        check("valid", 32'(gvalid), 32'(m_owner >= 0));
        check("timeout", 32'(tmo), 32'(m_tmo));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_model();
    endtask

    task automatic go_idle();
        req = 8'h00;
        rel = 1'b0;
        repeat (3) step();
    endtask

    initial begin
        rst  = 1'b1;
        req  = 8'h00;
        rel  = 1'b0;
        mode = 1'b0;
        model_reset();
        #12;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_index", 32'(gidx), 32'd0);
        check("rst_valid", 32'(gvalid), 32'd0);
        check("rst_tmo", 32'(tmo), 32'd0);
        rst = 1'b0;

        // Round-robin rotation from reset: 0..7 then 0, two idle cycles between grants.
        mode = 1'b1;
        req  = 8'hFF;
        for (int n = 0; n < 9; n++) begin
            step();
            check("rr_index", 32'(gidx), 32'(n % 8));
            check("rr_valid", 32'(gvalid), 32'd1);
            rel = 1'b1;
            step();
            check("rr_gap1", 32'(gvalid), 32'd0);
            rel = 1'b0;
            step();
            check("rr_gap2", 32'(gvalid), 32'd0);
        end

        // Fixed priority picks the highest asserted index.
        mode = 1'b0;
        req  = 8'b0010_0110;
        step();
        check("fixed_grant", 32'(grant), 32'h20);
        check("fixed_index", 32'(gidx), 32'd5);
        go_idle();

        // Timeout: four granted cycles, one pulse, re-grant two cycles later.
        req = 8'h08;
        for (int c = 0; c < 4; c++) begin
            step();
            check("to_hold", 32'(grant), 32'h08);
        end
        step();
        check("to_drop", 32'(gvalid), 32'd0);
        check("to_pulse", 32'(tmo), 32'd1);
        step();
        check("to_pulse_end", 32'(tmo), 32'd0);
        step();
        check("to_regrant", 32'(gidx), 32'd3);
        check("to_regrant_v", 32'(gvalid), 32'd1);

        // Release on the revoking edge wins over the timeout.
        repeat (3) step();
        check("co_held", 32'(grant), 32'h08);
        rel = 1'b1;
        step();
        check("co_drop", 32'(gvalid), 32'd0);
        check("co_nopulse", 32'(tmo), 32'd0);
        rel = 1'b0;
        go_idle();

        // Owner drops its request while others stay asserted.
        req = 8'b1000_0011;
        step();
        check("od_index", 32'(gidx), 32'd7);
        req = 8'b0000_0011;
        step();
        check("od_clear", 32'(gvalid), 32'd0);
        step();
        check("od_gap", 32'(gvalid), 32'd0);
        step();
        check("od_next", 32'(gidx), 32'd1);

        // Asynchronous reset mid-grant, then round-robin restarts at index 0.
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("mr_grant", 32'(grant), 32'd0);
        check("mr_valid", 32'(gvalid), 32'd0);
        check("mr_index", 32'(gidx), 32'd0);
        #1;
        rst  = 1'b0;
        mode = 1'b1;
        req  = 8'hFF;
        step();
        check("mr_rr_first", 32'(gidx), 32'd0);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(3) == 0) req = 8'($urandom);
            if ($urandom_range(7) == 0) req = 8'h00;
            rel  = ($urandom_range(4) == 0);
            mode = 1'($urandom);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
